// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: signal bundle between the UART receive controller and its environment
// Ports (master = line/sampler side, slave = controller side):
//   rx_in        serial line, idle high
//   par_en       parity bit present in frame
//   par_typ      0 = even, 1 = odd parity
//   sampled_bit  majority-voted bit from the data sampler
//   data_samp_en enables the data sampler
//   edge_cnt     tick index inside the current bit
//   p_data       last good received word
//   data_valid   one-cycle strobe for a new p_data
//   par_err      parity error flag of the last frame
//   stp_err      stop-bit error flag of the last frame
interface uart_rx_ctrl_if #(
    parameter int PRESCALE   = 16,
    parameter int DATA_WIDTH = 8
);
    logic                        rx_in;
    logic                        par_en;
    logic                        par_typ;
    logic                        sampled_bit;
    logic                        data_samp_en;
    logic [$clog2(PRESCALE)-1:0] edge_cnt;
    logic [DATA_WIDTH-1:0]       p_data;
    logic                        data_valid;
    logic                        par_err;
    logic                        stp_err;

    modport master (
        output rx_in, par_en, par_typ, sampled_bit,
        input  data_samp_en, edge_cnt, p_data, data_valid, par_err, stp_err
    );

    modport slave (
        input  rx_in, par_en, par_typ, sampled_bit,
        output data_samp_en, edge_cnt, p_data, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller (start/data/parity/stop sequencing)
// Ports:
//   clk    oversampling clock (PRESCALE ticks per bit)
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_ctrl_if slave modport (line, sampler handshake, received word and flags)
module uart_rx_ctrl #(
    parameter int PRESCALE   = 16,
    parameter int DATA_WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    uart_rx_ctrl_if.slave bus
);
    localparam int CW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  pen_q, pen_d;
    logic                  ptyp_q, ptyp_d;
    logic                  tick;

    assign tick             = edge_q == CW'(PRESCALE - 1);
    assign bus.data_samp_en = state_q != IDLE;
    assign bus.edge_cnt     = edge_q;
    assign bus.p_data       = pdata_q;
    assign bus.data_valid   = valid_q;
    assign bus.par_err      = perr_q;
    assign bus.stp_err      = serr_q;

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pdata_d = pdata_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        serr_d  = serr_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        if (state_q == IDLE) begin
            edge_d = '0;
            if (!bus.rx_in) begin
                state_d = START;
                perr_d  = 1'b0;
                serr_d  = 1'b0;
                pen_d   = bus.par_en;
                ptyp_d  = bus.par_typ;
            end
        end else begin
            // power-of-two PRESCALE makes the natural overflow the bit wrap
            edge_d = edge_q + 1'b1;
            if (tick) begin
                unique case (state_q)
                    START: begin
                        state_d = bus.sampled_bit ? IDLE : DATA;
                        bit_d   = '0;
                    end
                    DATA: begin
                        // LSB-first: new bit enters at the top and shifts down
                        shift_d = DATA_WIDTH'({bus.sampled_bit, shift_q} >> 1);
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BW'(DATA_WIDTH - 1))
                            state_d = pen_q ? PARITY : STOP;
                    end
                    PARITY: begin
                        perr_d  = bus.sampled_bit != (^shift_q ^ ptyp_q);
                        state_d = STOP;
                    end
                    STOP: begin
                        serr_d  = !bus.sampled_bit;
                        state_d = IDLE;
                        if (bus.sampled_bit && !perr_q) begin
                            pdata_d = shift_q;
                            valid_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pdata_q <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
    localparam int P = 16;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        int           det;
        int           nbits;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ctrl_if #(.PRESCALE(P), .DATA_WIDTH(W)) bus ();

    uart_rx_ctrl #(.PRESCALE(P), .DATA_WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic b);
        bus.rx_in       = b;
        bus.sampled_bit = b;
    endtask

    // sends one frame aligned to the controller's bit grid; PAR_EN/PAR_TYP are
    // inverted for the body of the frame so only the latched values may matter
    task automatic send_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic stop, input logic good);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pbit);
        bits.push_back(stop);
        bus.par_en  = pe;
        bus.par_typ = pt;
        if (good) sb.push_back('{d, cyc + 1, bits.size()});
        drv(1'b0);
        tick(1);
        bus.par_en  = ~pe;
        bus.par_typ = ~pt;
        for (int i = 1; i <= bits.size(); i++) begin
            tick(P);
            drv(i < bits.size() ? bits[i] : 1'b1);
        end
        bus.par_en  = pe;
        bus.par_typ = pt;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.data_valid) begin
            check("strobe_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("p_data", bus.p_data, e.data);
                check("latency", cyc - e.det + 1, e.nbits * P + 1);
            end
        end
    end

    initial begin
        drv(1'b1);
        bus.par_en  = 1'b0;
        bus.par_typ = 1'b0;
        tick(3);
        check("rst_edge_cnt", bus.edge_cnt, 0);
        check("rst_samp_en", bus.data_samp_en, 0);
        check("rst_p_data", bus.p_data, 0);
        check("rst_valid", bus.data_valid, 0);
        check("rst_par_err", bus.par_err, 0);
        check("rst_stp_err", bus.stp_err, 0);
        rst_n = 1'b1;
        tick(3);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(2);
        check("a5_par_err", bus.par_err, 0);
        check("a5_stp_err", bus.stp_err, 0);
        check("a5_idle_samp_en", bus.data_samp_en, 0);

        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(2);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("even_bad_par_err", bus.par_err, 1);
        check("even_bad_stp_err", bus.stp_err, 0);
        check("even_bad_valid", bus.data_valid, 0);
        tick(2);
        check("even_bad_p_data", bus.p_data, 8'h0F);

        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(2);
        check("odd_good_par_err", bus.par_err, 0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("stop_bad_stp_err", bus.stp_err, 1);
        check("stop_bad_par_err", bus.par_err, 0);
        tick(2);
        check("stop_bad_p_data", bus.p_data, 8'h01);

        bus.rx_in       = 1'b0;
        bus.sampled_bit = 1'b1;
        tick(1);
        tick(3);
        bus.rx_in = 1'b1;
        tick(12);
        check("glitch_edge_cnt_last", bus.edge_cnt, P - 1);
        check("glitch_samp_en_start", bus.data_samp_en, 1);
        tick(1);
        check("glitch_samp_en_idle", bus.data_samp_en, 0);
        check("glitch_edge_cnt_idle", bus.edge_cnt, 0);
        check("glitch_par_err", bus.par_err, 0);
        check("glitch_stp_err", bus.stp_err, 0);
        check("glitch_p_data", bus.p_data, 8'h01);
        tick(4);

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(3);
        check("b2b_p_data", bus.p_data, 8'hAA);

        drv(1'b0);
        tick(1);
        tick(P);
        drv(1'b1);
        tick(P);
        drv(1'b0);
        tick(P);
        drv(1'b1);
        tick(P);
        drv(1'b1);
        tick(P / 2);
        rst_n = 1'b0;
        #1;
        check("abort_edge_cnt", bus.edge_cnt, 0);
        check("abort_samp_en", bus.data_samp_en, 0);
        check("abort_p_data", bus.p_data, 0);
        check("abort_valid", bus.data_valid, 0);
        check("abort_par_err", bus.par_err, 0);
        check("abort_stp_err", bus.stp_err, 0);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_samp_en", bus.data_samp_en, 0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(5);
        check("post_rst_p_data", bus.p_data, 8'h81);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
